// File: rtl/vio_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter in front of versatile_io:
// FSM state encoding, watchdog counter width and bus widths.
package vio_arb_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_e;

endpackage : vio_arb_pkg

// File: rtl/vio_wb_arbiter_if.sv
// Bundle of both master ports and the shared slave port of the arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the masters and models the slave.
interface vio_wb_arbiter_if;
  import vio_arb_pkg::*;

  // master 0
  logic             m0_cyc_i, m0_stb_i, m0_we_i;
  logic [ADR_W-1:0] m0_adr_i;
  logic [DAT_W-1:0] m0_dat_i;
  logic [SEL_W-1:0] m0_sel_i;
  logic [DAT_W-1:0] m0_dat_o;
  logic             m0_ack_o, m0_err_o;
  // master 1
  logic             m1_cyc_i, m1_stb_i, m1_we_i;
  logic [ADR_W-1:0] m1_adr_i;
  logic [DAT_W-1:0] m1_dat_i;
  logic [SEL_W-1:0] m1_sel_i;
  logic [DAT_W-1:0] m1_dat_o;
  logic             m1_ack_o, m1_err_o;
  // shared slave port
  logic             wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [ADR_W-1:0] wbs_adr_o;
  logic [DAT_W-1:0] wbs_dat_o;
  logic [SEL_W-1:0] wbs_sel_o;
  logic [DAT_W-1:0] wbs_dat_i;
  logic             wbs_ack_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o,
    input  wbs_dat_i, wbs_ack_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o,
    output wbs_dat_i, wbs_ack_i
  );

endinterface : vio_wb_arbiter_if

// File: rtl/vio_arb_timer.sv
// Stall watchdog for the arbiter: counts granted cycles where the strobe is
// high and the slave has not acknowledged, and flags expiry at TIMEOUT-1 so the
// FSM can abort on the following edge.
module vio_arb_timer
  import vio_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  input  logic i_stb,
  input  logic i_ack,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Stall counter: held at zero outside a grant and cleared by every ack.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_active || i_ack) begin
      r_cnt <= '0;
    end else if (i_stb) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_active && !i_ack && (r_cnt == LIMIT);

endmodule : vio_arb_timer

// File: rtl/vio_wb_arbiter.sv
// Two-master Wishbone arbiter for the versatile_io slave port.
// Registered grant, round-robin on contention, no pre-emption while cyc is held.
// Optional stall watchdog enabled by defining VIO_ARB_TIMEOUT_EN.
module vio_wb_arbiter
  import vio_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              wbs_clk,
  input  logic              wbs_rst,
  vio_wb_arbiter_if.slave   bus
);

  arb_state_e r_state, w_state_nxt;
  logic       r_last, w_last_nxt;
  logic       w_gnt0, w_gnt1, w_expire;

  logic             w_cyc, w_stb, w_we;
  logic [ADR_W-1:0] w_adr;
  logic [DAT_W-1:0] w_dat;
  logic [SEL_W-1:0] w_sel;
  logic             w_ack0, w_ack1, w_err0, w_err1;
  logic [DAT_W-1:0] w_rdat0, w_rdat1;

  assign w_gnt0 = (r_state == ST_GNT0);
  assign w_gnt1 = (r_state == ST_GNT1);

`ifdef VIO_ARB_TIMEOUT_EN
  vio_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk    (wbs_clk),
    .i_rst    (wbs_rst),
    .i_active (w_gnt0 || w_gnt1),
    .i_stb    (w_stb),
    .i_ack    (bus.wbs_ack_i),
    .o_expire (w_expire)
  );
`else
  // Timeout limit has no effect when the watchdog is compiled out.
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_expire         = 1'b0;
`endif

  // State and last-granted registers; reset leaves master 0 first in line.
  always_ff @(posedge wbs_clk or posedge wbs_rst) begin
    if (wbs_rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, hold the grant until the owner drops cyc.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i) w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
        else if (bus.m0_cyc_i)            w_state_nxt = ST_GNT0;
        else if (bus.m1_cyc_i)            w_state_nxt = ST_GNT1;
      end
      ST_GNT0: begin
        if (!bus.m0_cyc_i) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b0;
        end else if (w_expire) begin
          w_state_nxt = ST_ABORT;
          w_last_nxt  = 1'b0;
        end
      end
      ST_GNT1: begin
        if (!bus.m1_cyc_i) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b1;
        end else if (w_expire) begin
          w_state_nxt = ST_ABORT;
          w_last_nxt  = 1'b1;
        end
      end
      ST_ABORT: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: route the granted master to the slave port and the slave response back.
  always_comb begin
    w_cyc   = 1'b0;
    w_stb   = 1'b0;
    w_we    = 1'b0;
    w_adr   = '0;
    w_dat   = '0;
    w_sel   = '0;
    w_ack0  = 1'b0;
    w_ack1  = 1'b0;
    w_rdat0 = '0;
    w_rdat1 = '0;
    w_err0  = 1'b0;
    w_err1  = 1'b0;
    if (w_gnt0) begin
      w_cyc   = bus.m0_cyc_i;
      w_stb   = bus.m0_stb_i;
      w_we    = bus.m0_we_i;
      w_adr   = bus.m0_adr_i;
      w_dat   = bus.m0_dat_i;
      w_sel   = bus.m0_sel_i;
      w_ack0  = bus.wbs_ack_i;
      w_rdat0 = bus.wbs_ack_i ? bus.wbs_dat_i : '0;
    end else if (w_gnt1) begin
      w_cyc   = bus.m1_cyc_i;
      w_stb   = bus.m1_stb_i;
      w_we    = bus.m1_we_i;
      w_adr   = bus.m1_adr_i;
      w_dat   = bus.m1_dat_i;
      w_sel   = bus.m1_sel_i;
      w_ack1  = bus.wbs_ack_i;
      w_rdat1 = bus.wbs_ack_i ? bus.wbs_dat_i : '0;
    end
`ifdef VIO_ARB_TIMEOUT_EN
    if (r_state == ST_ABORT) begin
      w_err0 = !r_last;
      w_err1 = r_last;
    end
`endif
  end

  assign bus.wbs_cyc_o = w_cyc;
  assign bus.wbs_stb_o = w_stb;
  assign bus.wbs_we_o  = w_we;
  assign bus.wbs_adr_o = w_adr;
  assign bus.wbs_dat_o = w_dat;
  assign bus.wbs_sel_o = w_sel;
  assign bus.m0_ack_o  = w_ack0;
  assign bus.m1_ack_o  = w_ack1;
  assign bus.m0_dat_o  = w_rdat0;
  assign bus.m1_dat_o  = w_rdat1;
  assign bus.m0_err_o  = w_err0;
  assign bus.m1_err_o  = w_err1;

endmodule : vio_wb_arbiter

// File: tb/tb_vio_wb_arbiter.sv
// Directed bench for vio_wb_arbiter: registered grant, round-robin alternation,
// read data routing, multi-beat hold, asynchronous reset and (when
// VIO_ARB_TIMEOUT_EN is defined) the stall abort with TIMEOUT = 4.
module tb_vio_wb_arbiter;

`ifdef VIO_ARB_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  localparam logic [31:0] ADR0 = 32'h1000_0040;
  localparam logic [31:0] ADR1 = 32'h2000_0080;

  logic wbs_clk = 1'b0;
  logic wbs_rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  vio_wb_arbiter_if bus ();

  vio_wb_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .wbs_clk (wbs_clk),
    .wbs_rst (wbs_rst),
    .bus     (bus.slave)
  );

  always #5 wbs_clk = ~wbs_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge wbs_clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic cyc);
    if (m == 0) begin bus.m0_cyc_i = cyc; bus.m0_stb_i = cyc; end
    else        begin bus.m1_cyc_i = cyc; bus.m1_stb_i = cyc; end
  endtask

  // One contention round: both masters request in IDLE, expected winner is
  // granted next cycle, receives one acked read beat, then releases.
  task automatic round(input int exp_m, input logic [31:0] rdata);
    logic [31:0] exp_adr;
    exp_adr = (exp_m == 0) ? ADR0 : ADR1;
    check($sformatf("idle_cyc_r%0d", exp_m), {31'd0, bus.wbs_cyc_o}, 32'd0);
    tick();
    check($sformatf("gnt_cyc_m%0d", exp_m), {31'd0, bus.wbs_cyc_o}, 32'd1);
    check($sformatf("gnt_adr_m%0d", exp_m), bus.wbs_adr_o, exp_adr);
    bus.wbs_ack_i = 1'b1;
    bus.wbs_dat_i = rdata;
    #1;
    check($sformatf("ack0_m%0d", exp_m), {31'd0, bus.m0_ack_o}, (exp_m == 0) ? 32'd1 : 32'd0);
    check($sformatf("ack1_m%0d", exp_m), {31'd0, bus.m1_ack_o}, (exp_m == 1) ? 32'd1 : 32'd0);
    check($sformatf("dat0_m%0d", exp_m), bus.m0_dat_o, (exp_m == 0) ? rdata : 32'd0);
    check($sformatf("dat1_m%0d", exp_m), bus.m1_dat_o, (exp_m == 1) ? rdata : 32'd0);
    tick();
    bus.wbs_ack_i = 1'b0;
    bus.wbs_dat_i = '0;
    set_req(exp_m, 1'b0);
    tick();
    check($sformatf("bubble_cyc_m%0d", exp_m), {31'd0, bus.wbs_cyc_o}, 32'd0);
    set_req(exp_m, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0; bus.m0_adr_i = ADR0;
    bus.m0_dat_i = 32'h0000_1111; bus.m0_sel_i = 4'hF;
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0; bus.m1_adr_i = ADR1;
    bus.m1_dat_i = 32'h0000_2222; bus.m1_sel_i = 4'h3;
    bus.wbs_ack_i = 0; bus.wbs_dat_i = '0;

    // Reset state
    #12;
    check("rst_cyc", {31'd0, bus.wbs_cyc_o}, 32'd0);
    check("rst_adr", bus.wbs_adr_o, 32'd0);
    check("rst_err", {30'd0, bus.m1_err_o, bus.m0_err_o}, 32'd0);
    tick();
    wbs_rst = 1'b0;
    tick();

    // Slave ack with no grant is ignored
    bus.wbs_ack_i = 1'b1;
    bus.wbs_dat_i = 32'hDEAD_BEEF;
    #1;
    check("idle_ack", {30'd0, bus.m1_ack_o, bus.m0_ack_o}, 32'd0);
    check("idle_dat", bus.m0_dat_o | bus.m1_dat_o, 32'd0);
    bus.wbs_ack_i = 1'b0;
    bus.wbs_dat_i = '0;
    tick();

    // Simultaneous requests, then strict alternation over several rounds
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    round(0, 32'h1234_5678);
    round(1, 32'hA5A5_A5A5);
    round(0, 32'h0F0F_0F0F);
    round(1, 32'h5A5A_5A5A);

    // m0 holds cyc over three acked beats while m1 keeps requesting
    tick();
    check("hold_gnt", bus.wbs_adr_o, ADR0);
    for (int b = 0; b < 3; b++) begin
      bus.m0_stb_i  = 1'b1;
      bus.wbs_ack_i = 1'b1;
      bus.wbs_dat_i = 32'hB000_0000 + b;
      #1;
      check($sformatf("hold_ack%0d", b), {30'd0, bus.m1_ack_o, bus.m0_ack_o}, 32'd1);
      tick();
      bus.m0_stb_i  = 1'b0;
      bus.wbs_ack_i = 1'b0;
      #1;
      check($sformatf("hold_cyc%0d", b), {31'd0, bus.wbs_cyc_o}, 32'd1);
      check($sformatf("hold_adr%0d", b), bus.wbs_adr_o, ADR0);
      tick();
    end
    set_req(0, 1'b0);
    tick();
    check("hold_bubble", {31'd0, bus.wbs_cyc_o}, 32'd0);
    tick();
    check("hold_then_m1", bus.wbs_adr_o, ADR1);

    // Asynchronous reset while GNT1 has stb high and the slave acks
    bus.wbs_ack_i = 1'b1;
    bus.wbs_dat_i = 32'hCAFE_F00D;
    #1;
    check("pre_rst_ack1", {31'd0, bus.m1_ack_o}, 32'd1);
    #1;
    wbs_rst = 1'b1;
    #1;
    check("async_rst_cyc", {31'd0, bus.wbs_cyc_o}, 32'd0);
    check("async_rst_adr", bus.wbs_adr_o, 32'd0);
    check("async_rst_ack", {30'd0, bus.m1_ack_o, bus.m0_ack_o}, 32'd0);
    check("async_rst_dat", bus.m1_dat_o, 32'd0);
    bus.wbs_ack_i = 1'b0;
    bus.wbs_dat_i = '0;
    set_req(0, 1'b1);
    tick();
    wbs_rst = 1'b0;
    tick();
    check("post_rst_gnt", bus.wbs_adr_o, ADR0);
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    tick();
    tick();

    // Stalled slave: m0 alone, no ack ever
    set_req(0, 1'b1);
    tick();
`ifdef VIO_ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      check($sformatf("stall_cyc%0d", c), {31'd0, bus.wbs_cyc_o}, 32'd1);
      check($sformatf("stall_err%0d", c), {31'd0, bus.m0_err_o}, 32'd0);
      tick();
    end
    check("abort_err0", {31'd0, bus.m0_err_o}, 32'd1);
    check("abort_err1", {31'd0, bus.m1_err_o}, 32'd0);
    check("abort_cyc", {31'd0, bus.wbs_cyc_o}, 32'd0);
    set_req(0, 1'b0);
    tick();
    check("abort_end_err", {31'd0, bus.m0_err_o}, 32'd0);
    check("abort_idle_cyc", {31'd0, bus.wbs_cyc_o}, 32'd0);
`else
    for (int c = 0; c < 8; c++) begin
      check($sformatf("stall_cyc%0d", c), {31'd0, bus.wbs_cyc_o}, 32'd1);
      check($sformatf("stall_err%0d", c), {30'd0, bus.m1_err_o, bus.m0_err_o}, 32'd0);
      tick();
    end
    set_req(0, 1'b0);
    tick();
    check("stall_release", {31'd0, bus.wbs_cyc_o}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_vio_wb_arbiter
